// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding and default
// widths/limits used by apb_master and its optional watchdog.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_W         = 12;
  localparam int APB_DATA_W         = 32;
  localparam int APB_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/apb_wdt.sv
// Wait-state watchdog for the APB master. An 8-bit counter cleared on the way
// into ACCESS and advanced on every stalled ACCESS cycle; 'expired' is high
// once the count equals LIMIT. Only built when APB_MASTER_TIMEOUT_EN is defined.
module apb_wdt
  import apb_pkg::*;
#(
  parameter int LIMIT = APB_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  logic [7:0] count;

  // Count stalled cycles, freezing at the limit so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LIMIT_C);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts one command on a valid/ready request
// channel, runs the SETUP/ACCESS handshake, and returns a one-cycle response.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase that
// waits TIMEOUT_CYCLES stalled cycles, reporting it as an error response.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  apb_state_t state, state_next;
  logic       done;
  logic       timeout;

  // A transfer completes normally only while in ACCESS; pready is ignored elsewhere.
  assign done = (state == ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic wdt_expired;

  apb_wdt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == SETUP),
    .inc     ((state == ACCESS) && !pready),
    .expired (wdt_expired)
  );

  // A late pready on the expiry cycle still wins, hence the !pready term.
  assign timeout = (state == ACCESS) && !pready && wdt_expired;
`else
  assign timeout = 1'b0;
`endif

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the APB phase strobes, which depend on state alone.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (done || timeout) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the command on acceptance; these hold unchanged through SETUP and ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if ((state == IDLE) && cmd_valid) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
    end
  end

  // Response pulse; data and error stay put between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done || timeout;
      if (done) begin
        rsp_err   <= pslverr;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (timeout) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum number of ACCESS cycles waited for pready; legal range 1..255.
REQ-004 SHALL use a single clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports cmd_valid  input  1; cmd_ready  output  1; cmd_write  input  1; cmd_addr  input  ADDR_W; cmd_wdata  input  DATA_W. Together these form the request channel.
REQ-007 SHALL have ports rsp_valid  output  1; rsp_rdata  output  DATA_W; rsp_err  output  1. Together these form the response channel; rsp_valid is a one-cycle pulse.
REQ-008 SHALL have APB outputs psel, penable, pwrite (each 1 bit), paddr (ADDR_W) and pwdata (DATA_W).
REQ-009 SHALL have APB inputs pready (1), prdata (DATA_W) and pslverr (1).

Function
REQ-010 SHALL implement the FSM states IDLE, SETUP and ACCESS.
REQ-011 cmd_ready SHALL equal (state==IDLE) and be combinational from state only.
REQ-012 In IDLE, cmd_valid&cmd_ready SHALL capture cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata, and move the FSM to SETUP.
REQ-013 SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then move unconditionally to ACCESS.
REQ-014 ACCESS SHALL drive psel=1, penable=1, and hold paddr, pwrite and pwdata stable until exit.
REQ-015 In ACCESS with pready=1, the next edge SHALL move the FSM to IDLE, drop psel and penable, and pulse rsp_valid=1 for one cycle.
REQ-016 On that rsp_valid pulse, rsp_err SHALL equal the sampled pslverr.
REQ-017 On that rsp_valid pulse, rsp_rdata SHALL be the sampled prdata for reads and 0 for writes.
REQ-018 In ACCESS with pready=0, the FSM SHALL remain in ACCESS (wait state) with all outputs held.
REQ-019 Zero-wait-state latency SHALL be: accept T0, SETUP T1, ACCESS T2, rsp_valid and IDLE at T3; peak throughput is one transfer per 3 cycles.
REQ-020 cmd_valid asserted outside IDLE SHALL be ignored; the requester holds it until cmd_ready.
REQ-021 rsp_rdata and rsp_err SHALL hold their value until the next rsp_valid pulse.
REQ-022 pready, prdata and pslverr SHALL be ignored outside ACCESS.

Reset
REQ-023 rst=1 SHALL, on the next edge, force the FSM to IDLE from any state, including mid-transfer.
REQ-024 That reset edge SHALL also clear psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_err to 0.
REQ-025 A transfer aborted by reset SHALL produce no rsp_valid.

Configuration
REQ-026 With APB_MASTER_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with pready=0.
REQ-027 With APB_MASTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES with pready still 0, the next edge SHALL go to IDLE, drop psel/penable, and pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-028 With APB_MASTER_TIMEOUT_EN defined, pready=1 on the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal completion.
REQ-029 Without APB_MASTER_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait indefinitely.

Structure
REQ-030 Package apb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2) and the default ADDR_W, DATA_W and TIMEOUT_CYCLES constants.
REQ-031 The timeout counter SHALL be sub-module apb_wdt (inputs clr, inc; output expired), instantiated only under APB_MASTER_TIMEOUT_EN.
REQ-032 All other logic SHALL stay in apb_master.

Verification
REQ-033 Write, zero wait: addr 0x004, wdata 0xDEADBEEF, pready tied 1 -> psel rises T1, penable T2, rsp_valid T3, rsp_err 0, paddr/pwdata stable T1-T2.
REQ-034 Read, 2 wait states: addr 0x008, pready low 2 ACCESS cycles, prdata 0x12345678 -> rsp_valid 5 cycles after accept, rsp_rdata 0x12345678.
REQ-035 Slave error: write with pslverr=1 alongside pready -> rsp_err=1; back-to-back cmd_valid accepted at the rsp_valid cycle, i.e. the next SETUP 1 cycle later.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=4): pready held 0 -> exit after 4 wait cycles, rsp_err=1, rsp_rdata=0; macro off -> still in ACCESS after 1000 cycles.
REQ-037 Reset mid-ACCESS: rst=1 during a wait state -> next edge psel=penable=0, cmd_ready=1, no rsp_valid.
